// File: rtl/pipe_stage_buffer.sv
// Elastic inter-stage buffer: DEPTH-entry first-word-fall-through queue
// with valid/ready handshake on both sides and a synchronous flush.
module pipe_stage_buffer #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    input  logic             ready_i,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push;
    logic             pop;

    // Handshake outputs come only from registered state.
    assign ready_o = (cnt_q != CW'(DEPTH));
    assign valid_o = (cnt_q != '0);
    assign data_o  = valid_o ? mem_q[rp_q] : '0;
    assign count_o = cnt_q;

    assign push = valid_i & ready_o;
    assign pop  = valid_o & ready_i;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wp_d = wp_q + AW'(1);
            if (pop)  rp_d = rp_q + AW'(1);
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload storage is not reset; data_o is masked while empty.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) mem_q[wp_q] <= data_i;
    end

endmodule

// File: doc/pipe_stage_buffer.md
# pipe_stage_buffer

Parametrised elastic inter-stage buffer for the vector pipeline. It replaces the single load/flush register between stages with a DEPTH-entry first-word-fall-through queue and a valid/ready handshake on both sides. A producer stage can keep issuing while the consumer stalls, up to DEPTH entries. A synchronous flush discards all in-flight contents, for example on a mispredict or exception squash.

## Interface
- WIDTH, 64, payload width in bits (≥1)
- DEPTH, 2, number of entries (power of two, ≥2)
- CW, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

- clk_i  in  1  clock, all state updates on rising edge
- rstn_i  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous flush, empties buffer
- valid_i  in  1  upstream payload valid
- data_i  in  WIDTH  upstream payload
- ready_o  out  1  buffer can accept an entry this cycle
- valid_o  out  1  head entry valid
- data_o  out  WIDTH  head entry payload
- ready_i  in  1  downstream accepts head this cycle
- count_o  out  CW  current occupancy, 0..DEPTH

## Operation
- Storage is a circular array of DEPTH entries with write pointer wp, read pointer rp (log2(DEPTH) bits each, natural wrap) and occupancy cnt (CW bits).
- push = valid_i & ready_o; pop = valid_o & ready_i.
- ready_o = (cnt != DEPTH); depends only on registered state, with no combinational path from ready_i.
- valid_o = (cnt != 0); data_o = mem[rp] when valid_o, else all-zero. data_o must never show stale data while valid_o=0.
- count_o = cnt.
- Priority per edge: reset > flush > push/pop.
- On flush: cnt←0, wp←0, rp←0. Any push or pop in that cycle is discarded. Storage contents need not be cleared, but data_o reads zero because valid_o=0.
- On push: mem[wp]←data_i, wp←wp+1.
- On pop: rp←rp+1.
- cnt updates as follows: push only +1; pop only −1; both or neither unchanged.
- Simultaneous push and pop at cnt=DEPTH is impossible because ready_o=0. At 0<cnt<DEPTH, both occur and cnt is unchanged. At cnt=0 a pop is impossible, so there is no same-cycle bypass.
- Upstream must hold data_i/valid_i stable while valid_i=1 and ready_o=0. Downstream sees head data stable while valid_o=1 and ready_i=0. The buffer guarantees the latter.
- Order preserved: entries leave strictly in acceptance order.

## Timing
- Reset values: valid_o=0, data_o=0, ready_o=1, count_o=0; pointers are 0. Reset assertion mid-operation clears state immediately (asynchronously), and all in-flight data is lost.
- Latency: an entry pushed at edge k is visible on valid_o/data_o after edge k (1 cycle) if the buffer was empty. Otherwise it follows the entries ahead of it.
- Throughput: 1 entry/cycle sustained when ready_i=1 continuously.
- Backpressure: after DEPTH consecutive pushes with ready_i=0 from empty, ready_o falls after the DEPTH-th edge. It rises the cycle after the first pop.
- Flush: takes effect at the edge where flush_i=1. From the following cycle valid_o=0, ready_o=1, count_o=0. A push in the cycle after the flush is accepted normally.
- Pointer wrap-around: wp and rp wrap from DEPTH−1 to 0 without a gap or bubble.

## Test plan
- Reset: rstn_i low mid-stream with cnt=2 → immediately valid_o=0, data_o=0, ready_o=1, count_o=0; the first push after release appears 1 cycle later.
- Streaming (DEPTH=2): push 0x1..0x8 on consecutive cycles with ready_i=1 → data_o shows 0x1..0x8 on consecutive cycles starting 1 cycle after the first push, count_o=1 throughout, no bubbles.
- Fill/stall: ready_i=0, push 0xA, 0xB → ready_o=0 after the second edge and count_o=2; a third offered 0xC is not accepted. Raise ready_i → output is 0xA then 0xB, and 0xC is accepted the cycle ready_o returns to 1.
- Flush priority: cnt=1, and in the same cycle flush_i=1, valid_i=1 (0x55), ready_i=1 → next cycle count_o=0, valid_o=0, data_o=0; 0x55 never emerges.
- Wrap-around (DEPTH=4): 10 pushes with a random ready_i pattern → output sequence equals input order, count_o matches the scoreboard every cycle, and there is no loss or duplication.
- Stable-under-stall: valid_o=1, ready_i=0 for 5 cycles while upstream pushes → data_o is unchanged across all 5 cycles.
